// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter : round-robin sharing of one sprite ROM among N_REQ
//                      sprite controllers, with a one-hot tagged return path.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sprite_rom_arbiter #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 24,
   parameter int RD_LAT = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_i,
   input  logic [N_REQ*ADDR_W-1:0]   addr_i,
   output logic [N_REQ-1:0]          gnt_o,
   output logic [ADDR_W-1:0]         mem_address_o,
   output logic                      mem_en_o,
   input  logic [DATA_W-1:0]         mem_data_i,
   output logic [DATA_W-1:0]         data_o,
   output logic [N_REQ-1:0]          valid_o
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  ptr_d;
   logic [N_REQ-1:0]  gnt;
   logic [PTR_W-1:0]  win_idx;
   logic              win_found;
   logic [ADDR_W-1:0] win_addr;
   int                scan_idx;
   logic [N_REQ-1:0]  ret_q [RD_LAT];

   // Scan from ptr upward with wrap; the first active request wins.
   always_comb begin
      gnt       = '0;
      win_idx   = '0;
      win_found = 1'b0;
      win_addr  = '0;
      scan_idx  = 0;
      if (!rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= N_REQ) begin
               scan_idx = scan_idx - N_REQ;
            end
            if (!win_found && req_i[scan_idx]) begin
               win_found       = 1'b1;
               win_idx         = PTR_W'(scan_idx);
               gnt[scan_idx]   = 1'b1;
               win_addr        = addr_i[scan_idx*ADDR_W +: ADDR_W];
            end
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (win_found) begin
         ptr_d = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         for (int s = 0; s < RD_LAT; s++) begin
            ret_q[s] <= '0;
         end
      end else begin
         ptr_q    <= ptr_d;
         ret_q[0] <= gnt;
         for (int s = 1; s < RD_LAT; s++) begin
            ret_q[s] <= ret_q[s-1];
         end
      end
   end

   assign gnt_o         = gnt;
   assign mem_en_o      = win_found;
   assign mem_address_o = win_addr;

   // Masking with rst drops a return already in the last stage when reset hits.
   assign valid_o = rst ? '0 : ret_q[RD_LAT-1];
   assign data_o  = (|valid_o) ? mem_data_i : '0;

endmodule

`default_nettype wire
